// File: rtl/spi_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_master
//   Single-frame SPI master, mode 0 (spi_clk idles low, data sampled on the
//   rising edge, changed on the falling edge). Each transaction is one 16-bit
//   frame {rw, 1'b0, address[5:0], data[7:0]} sent MSB first; for reads the
//   data byte is 8'h00 and the last 8 miso bits become rd_data.
//
//   Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
//   With start accepted at the end of cycle 0, cs_n falls in cycle 1 and done
//   pulses (with cs_n rising) in cycle 1 + 34*CLK_DIV.
//
// Parameters
//   CLK_DIV  spi_clk half-period in clock cycles (2..255)
//
// Ports
//   clock    main clock, rising-edge
//   reset_n  asynchronous active-low reset
//   start    transaction request, only looked at in IDLE
//   rw       1 = read, 0 = write (captured at accept)
//   address  6-bit register address (captured at accept)
//   wr_data  write data (captured at accept)
//   busy     high from the cycle after accept through the end of GAP
//   done     one-cycle completion pulse
//   rd_data  result of the most recent read
//   spi_clk  SPI clock
//   cs_n     active-low chip select
//   mosi     master out / slave in
//   miso     master in / slave out
// -----------------------------------------------------------------------------
module spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [5:0] address,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       spi_clk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV - 1);
   localparam logic [4:0] FRAME_BITS = 5'd16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  half_cnt, half_cnt_nxt;
   logic [4:0]  bit_cnt, bit_cnt_nxt;
   logic [15:0] tx_sr, tx_sr_nxt;
   logic [7:0]  rx_sr, rx_sr_nxt;
   logic        rw_q, rw_q_nxt;
   logic        busy_nxt, done_nxt, spi_clk_nxt, cs_n_nxt, mosi_nxt;
   logic [7:0]  rd_data_nxt;
   logic        half_end;
   logic [4:0]  bit_cnt_inc;

   function automatic logic [15:0] build_frame(input logic       r,
                                               input logic [5:0] a,
                                               input logic [7:0] d);
      return {r, 1'b0, a, (r ? 8'h00 : d)};
   endfunction

   // Next-state and next-output logic. Every output is registered, so the
   // pins come straight from flops.
   always_comb begin
      state_nxt    = state;
      half_cnt_nxt = half_cnt;
      bit_cnt_nxt  = bit_cnt;
      tx_sr_nxt    = tx_sr;
      rx_sr_nxt    = rx_sr;
      rw_q_nxt     = rw_q;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      spi_clk_nxt  = spi_clk;
      cs_n_nxt     = cs_n;
      mosi_nxt     = mosi;
      rd_data_nxt  = rd_data;
      half_end     = (half_cnt == HALF_LAST);
      bit_cnt_inc  = bit_cnt + 5'd1;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = SETUP;
               rw_q_nxt     = rw;
               tx_sr_nxt    = build_frame(rw, address, wr_data);
               mosi_nxt     = rw;          // frame bit 15 is the rw flag
               cs_n_nxt     = 1'b0;
               busy_nxt     = 1'b1;
               spi_clk_nxt  = 1'b0;
               half_cnt_nxt = 8'd0;
               bit_cnt_nxt  = 5'd0;
            end
         end

         SETUP: begin
            if (half_end) begin
               state_nxt    = SHIFT;
               half_cnt_nxt = 8'd0;
               spi_clk_nxt  = 1'b1;
               rx_sr_nxt    = {rx_sr[6:0], miso};
            end else begin
               half_cnt_nxt = half_cnt + 8'd1;
            end
         end

         SHIFT: begin
            if (!half_end) begin
               half_cnt_nxt = half_cnt + 8'd1;
            end else begin
               half_cnt_nxt = 8'd0;
               if (spi_clk) begin
                  // Falling edge: count the bit, advance mosi unless it was the last one.
                  spi_clk_nxt = 1'b0;
                  bit_cnt_nxt = bit_cnt_inc;
                  if (bit_cnt_inc != FRAME_BITS) begin
                     mosi_nxt  = tx_sr[14];
                     tx_sr_nxt = {tx_sr[14:0], 1'b0};
                  end
               end else if (bit_cnt == FRAME_BITS) begin
                  // Low half of the 16th period is over.
                  state_nxt = HOLD;
               end else begin
                  spi_clk_nxt = 1'b1;
                  rx_sr_nxt   = {rx_sr[6:0], miso};
               end
            end
         end

         HOLD: begin
            if (half_end) begin
               state_nxt    = GAP;
               half_cnt_nxt = 8'd0;
               cs_n_nxt     = 1'b1;
               done_nxt     = 1'b1;
               if (rw_q) begin
                  rd_data_nxt = rx_sr;
               end
            end else begin
               half_cnt_nxt = half_cnt + 8'd1;
            end
         end

         GAP: begin
            if (half_end) begin
               state_nxt    = IDLE;
               half_cnt_nxt = 8'd0;
               bit_cnt_nxt  = 5'd0;
               busy_nxt     = 1'b0;
            end else begin
               half_cnt_nxt = half_cnt + 8'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         half_cnt <= 8'd0;
         bit_cnt  <= 5'd0;
         tx_sr    <= 16'h0000;
         rx_sr    <= 8'h00;
         rw_q     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         spi_clk  <= 1'b0;
         cs_n     <= 1'b1;
         mosi     <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         state    <= state_nxt;
         half_cnt <= half_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         tx_sr    <= tx_sr_nxt;
         rx_sr    <= rx_sr_nxt;
         rw_q     <= rw_q_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         spi_clk  <= spi_clk_nxt;
         cs_n     <= cs_n_nxt;
         mosi     <= mosi_nxt;
         rd_data  <= rd_data_nxt;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_master
//   Two masters (CLK_DIV=4 and CLK_DIV=2) share all inputs; each has its own
//   mode-0 slave that returns resp MSB first and records the mosi word.
//   A cycle-offset model gives the expected pin values for every cycle.
// -----------------------------------------------------------------------------
module tb_spi_master;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        rw      = 1'b0;
   logic [5:0]  address = 6'h00;
   logic [7:0]  wr_data = 8'h00;
   logic [15:0] resp    = 16'h0000;

   logic [1:0]  busy_v, done_v, sck_v, cs_v, mosi_v;
   logic [1:0]  miso_v = 2'b00;
   logic [7:0]  rd_v [2];

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_master #(.CLK_DIV(g == 0 ? 4 : 2)) u_dut (
         .clock   (clock),
         .reset_n (reset_n),
         .start   (start),
         .rw      (rw),
         .address (address),
         .wr_data (wr_data),
         .busy    (busy_v[g]),
         .done    (done_v[g]),
         .rd_data (rd_v[g]),
         .spi_clk (sck_v[g]),
         .cs_n    (cs_v[g]),
         .mosi    (mosi_v[g]),
         .miso    (miso_v[g])
      );
   end

   function automatic int dv(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   // Model: t = cycles since accept (0 = idle). Frame occupies t = 1 .. 35*D.
   int          t_m  [2] = '{0, 0};
   logic [15:0] fr_m [2] = '{16'h0000, 16'h0000};
   logic        rw_m [2] = '{1'b0, 1'b0};
   logic [7:0]  rd_m [2] = '{8'h00, 8'h00};

   always @(posedge clock or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            t_m[i]  <= 0;
            rd_m[i] <= 8'h00;
         end else if (t_m[i] == 0) begin
            if (start) begin
               t_m[i]  <= 1;
               rw_m[i] <= rw;
               fr_m[i] <= {rw, 1'b0, address, (rw ? 8'h00 : wr_data)};
            end
         end else begin
            if ((t_m[i] + 1 == 1 + 34 * dv(i)) && rw_m[i]) rd_m[i] <= resp[7:0];
            t_m[i] <= (t_m[i] == 35 * dv(i)) ? 0 : t_m[i] + 1;
         end
      end
   end

   // Expected {cs_n, spi_clk, busy, done, mosi} at offset t into a frame.
   function automatic logic [4:0] exp_out(input int d, input int t, input logic [15:0] fr);
      logic cs, sck, bsy, dn, mo;
      int   k;
      if (t == 0) return 5'b10000;
      bsy = 1'b1;
      cs  = (t >= 1 + 34 * d);
      sck = (t >= 1 + d) && (t < 1 + 33 * d) && (((t - 1 - d) % (2 * d)) < d);
      dn  = (t == 1 + 34 * d);
      k   = (t - 1) / (2 * d);
      if (k > 15) k = 15;
      mo  = fr[15 - k];
      return {cs, sck, bsy, dn, mo};
   endfunction

   // Slave / monitor state
   int          falls [2] = '{0, 0};
   int          rises [2] = '{0, 0};
   logic [15:0] word  [2] = '{16'h0, 16'h0};
   logic [15:0] last_word [2] = '{16'h0, 16'h0};
   int          last_rises [2] = '{0, 0};
   int          last_falls [2] = '{0, 0};
   int          hi_run [2] = '{0, 0};
   int          last_gap [2] = '{0, 0};
   int          frames [2] = '{0, 0};
   int          done_cnt [2] = '{0, 0};
   int          last_done [2] = '{0, 0};
   int          prev_done [2] = '{0, 0};
   logic        cs_prev [2] = '{1'b1, 1'b1};
   logic        sck_prev [2] = '{1'b0, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic monitor_loop();
      logic [3:0] idx;
      forever begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            if (!cs_v[i] && cs_prev[i]) begin
               if (frames[i] > 0) last_gap[i] = hi_run[i];
               frames[i]++;
               falls[i] = 0;
               rises[i] = 0;
               word[i]  = 16'h0;
               miso_v[i] = resp[15];
            end
            if (!cs_v[i]) begin
               hi_run[i] = 0;
               if (sck_v[i] && !sck_prev[i]) begin
                  rises[i]++;
                  word[i] = {word[i][14:0], mosi_v[i]};
               end
               if (!sck_v[i] && sck_prev[i]) begin
                  falls[i]++;
                  if (falls[i] < 16) begin
                     idx = 4'(15 - falls[i]);
                     miso_v[i] = resp[idx];
                  end
               end
            end else begin
               hi_run[i]++;
               if (!cs_prev[i]) begin
                  last_word[i]  = word[i];
                  last_rises[i] = rises[i];
                  last_falls[i] = falls[i];
               end
            end
            if (done_v[i]) begin
               done_cnt[i]++;
               prev_done[i] = last_done[i];
               last_done[i] = cyc;
            end
            cs_prev[i]  = cs_v[i];
            sck_prev[i] = sck_v[i];
         end
      end
   endtask

   task automatic compare_loop();
      logic [4:0] e;
      forever begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            e = exp_out(dv(i), t_m[i], fr_m[i]);
            chk($sformatf("cs_n[%0d]", i),    32'(cs_v[i]),   32'(e[4]));
            chk($sformatf("spi_clk[%0d]", i), 32'(sck_v[i]),  32'(e[3]));
            chk($sformatf("busy[%0d]", i),    32'(busy_v[i]), 32'(e[2]));
            chk($sformatf("done[%0d]", i),    32'(done_v[i]), 32'(e[1]));
            chk($sformatf("rd_data[%0d]", i), 32'(rd_v[i]),   32'(rd_m[i]));
            if (!e[4]) chk($sformatf("mosi[%0d]", i), 32'(mosi_v[i]), 32'(e[0]));
         end
      end
   endtask

   task automatic wait_idle(input int bound);
      for (int k = 0; k < bound; k++) begin
         step();
         if (busy_v == 2'b00) break;
      end
      chk("idle_timeout", 32'(busy_v), 32'(0));
   endtask

   initial begin
      int c0;
      int d0 [2];
      fork
         monitor_loop();
         compare_loop();
      join_none

      // Reset values
      repeat (3) step();
      chk("rst_cs_n",    32'(cs_v),   32'(2'b11));
      chk("rst_spi_clk", 32'(sck_v),  32'(2'b00));
      chk("rst_busy",    32'(busy_v), 32'(2'b00));
      chk("rst_done",    32'(done_v), 32'(2'b00));
      chk("rst_rd_data", 32'(rd_v[0]), 32'(8'h00));
      reset_n = 1'b1;
      step();

      // Read: address 0x10, slave returns 0x3C in the second byte
      rw = 1'b1; address = 6'h10; wr_data = 8'hFF; resp = 16'hC33C;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      c0 = cyc; start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(300);
      chk("rd_word0",  32'(last_word[0]), 32'(16'h9000));
      chk("rd_word1",  32'(last_word[1]), 32'(16'h9000));
      chk("rd_data0",  32'(rd_v[0]), 32'(8'h3C));
      chk("rd_data1",  32'(rd_v[1]), 32'(8'h3C));
      chk("rd_dones0", 32'(done_cnt[0] - d0[0]), 32'(1));
      chk("rd_donecyc0", 32'(last_done[0] - c0), 32'(137));
      chk("rd_donecyc1", 32'(last_done[1] - c0), 32'(69));

      // Write: address 0x05, data 0xA5; inputs scrambled after accept
      rw = 1'b0; address = 6'h05; wr_data = 8'hA5; resp = 16'h5A5A;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      c0 = cyc; start = 1'b1;
      step();
      start = 1'b0; rw = 1'b1; address = 6'h3F; wr_data = 8'h00;
      wait_idle(300);
      chk("wr_word0",  32'(last_word[0]), 32'(16'h05A5));
      chk("wr_word1",  32'(last_word[1]), 32'(16'h05A5));
      chk("wr_rd0",    32'(rd_v[0]), 32'(8'h3C));
      chk("wr_rd1",    32'(rd_v[1]), 32'(8'h3C));
      chk("wr_donecyc0", 32'(last_done[0] - c0), 32'(137));
      chk("wr_donecyc1", 32'(last_done[1] - c0), 32'(69));
      chk("wr_rises0", 32'(last_rises[0]), 32'(16));
      chk("wr_falls0", 32'(last_falls[0]), 32'(16));
      chk("wr_rises1", 32'(last_rises[1]), 32'(16));
      chk("wr_falls1", 32'(last_falls[1]), 32'(16));

      // start pulsed at cycle 20 of an active frame is ignored
      rw = 1'b0; address = 6'h2A; wr_data = 8'h5C;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      c0 = cyc; start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
      start = 1'b1; rw = 1'b1; address = 6'h11;
      step();
      start = 1'b0; rw = 1'b0;
      wait_idle(300);
      repeat (3) step();
      chk("ign_dones0", 32'(done_cnt[0] - d0[0]), 32'(1));
      chk("ign_dones1", 32'(done_cnt[1] - d0[1]), 32'(1));
      chk("ign_word0",  32'(last_word[0]), 32'(16'h2A5C));
      chk("ign_word1",  32'(last_word[1]), 32'(16'h2A5C));
      chk("ign_busy",   32'(busy_v), 32'(2'b00));

      // Reset at cycle 50 of a read frame
      rw = 1'b1; address = 6'h10; wr_data = 8'h00; resp = 16'h00FF;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      c0 = cyc; start = 1'b1;
      step();
      start = 1'b0;
      repeat (49) step();
      chk("pre_rst_cs_n", 32'(cs_v), 32'(2'b00));
      #1 reset_n = 1'b0;
      #1;
      chk("arst_cs_n",    32'(cs_v),   32'(2'b11));
      chk("arst_spi_clk", 32'(sck_v),  32'(2'b00));
      chk("arst_busy",    32'(busy_v), 32'(2'b00));
      chk("arst_rd0",     32'(rd_v[0]), 32'(8'h00));
      chk("arst_rd1",     32'(rd_v[1]), 32'(8'h00));
      repeat (3) step();
      chk("arst_dones0", 32'(done_cnt[0] - d0[0]), 32'(0));
      chk("arst_dones1", 32'(done_cnt[1] - d0[1]), 32'(0));

      // start accepted on the first edge after reset release
      rw = 1'b0; address = 6'h21; wr_data = 8'h96; start = 1'b1;
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_cs_n", 32'(cs_v),   32'(2'b00));
      chk("post_rst_busy", 32'(busy_v), 32'(2'b11));
      start = 1'b0;
      wait_idle(300);
      chk("post_rst_word0", 32'(last_word[0]), 32'(16'h2196));
      chk("post_rst_word1", 32'(last_word[1]), 32'(16'h2196));
      chk("post_rst_rd0",   32'(rd_v[0]), 32'(8'h00));

      // start held high: back-to-back frames
      rw = 1'b0; address = 6'h0C; wr_data = 8'h3E; resp = 16'h0000;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      c0 = cyc; start = 1'b1;
      for (int k = 0; k < 400; k++) begin
         step();
         if (done_cnt[1] - d0[1] >= 2) break;
      end
      start = 1'b0;
      chk("held_dones1", 32'(done_cnt[1] - d0[1]), 32'(2));
      wait_idle(300);
      chk("held_first_done1",  32'(prev_done[1] - c0), 32'(69));
      chk("held_second_done1", 32'(last_done[1] - c0), 32'(140));
      chk("held_gap1",   32'(last_gap[1]), 32'(3));
      chk("held_word1",  32'(last_word[1]), 32'(16'h0C3E));
      chk("held_rises1", 32'(last_rises[1]), 32'(16));
      chk("held_falls1", 32'(last_falls[1]), 32'(16));
      chk("held_dones0", 32'(done_cnt[0] - d0[0]), 32'(1));
      chk("held_donecyc0", 32'(last_done[0] - c0), 32'(137));
      chk("held_word0",  32'(last_word[0]), 32'(16'h0C3E));

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the spi_clk half-period in clock cycles; legal range is 2..255.
REQ-002 SHALL have port clock, input, 1 bit: the main clock; all state is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: transaction request, sampled in IDLE only.
REQ-005 SHALL have port rw, input, 1 bit: 1 = read, 0 = write; captured when start is accepted.
REQ-006 SHALL have port address, input, 6 bits: register address; captured when start is accepted.
REQ-007 SHALL have port wr_data, input, 8 bits: write data; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after accept through the end of GAP.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at transaction completion.
REQ-010 SHALL have port rd_data, output, 8 bits: last read result.
REQ-011 SHALL have port spi_clk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-012 SHALL have port cs_n, output, 1 bit: active-low chip select.
REQ-013 SHALL have port mosi, output, 1 bit: master out, slave in.
REQ-014 SHALL have port miso, input, 1 bit: master in, slave out.

Function
REQ-015 Frame SHALL be 16 bits, MSB first: {rw, 1'b0, address[5:0], data[7:0]}; data = captured wr_data for writes and 8'h00 for reads.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP, sequenced IDLE->SETUP->SHIFT->HOLD->GAP->IDLE.
REQ-017 In IDLE with start=1, SHALL capture rw/address/wr_data, and on the next cycle (cycle 1) drive cs_n=0, busy=1 and mosi=frame bit 15.
REQ-018 SETUP SHALL last CLK_DIV cycles with spi_clk=0, then enter SHIFT.
REQ-019 SHIFT SHALL produce 16 spi_clk periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
REQ-020 miso SHALL be sampled into a shift register in the clock cycle spi_clk goes 0->1.
REQ-021 mosi SHALL advance to the next frame bit in the clock cycle spi_clk goes 1->0, except after the 16th bit, where it holds.
REQ-022 After the 16th falling edge, HOLD SHALL keep cs_n=0 and spi_clk=0 for CLK_DIV cycles.
REQ-023 At the end of HOLD, SHALL drive cs_n=1 and pulse done=1 in the same cycle, cycle 1+34*CLK_DIV.
REQ-024 At the done pulse, rd_data SHALL load the last 8 sampled miso bits for reads and SHALL remain unchanged for writes.
REQ-025 GAP SHALL hold cs_n=1 and busy=1 for CLK_DIV cycles, then return to IDLE with busy=0.
REQ-026 The minimum cs_n-high time between frames SHALL be CLK_DIV+1 cycles.
REQ-027 start SHALL be ignored while busy=1; no queuing.
REQ-028 start held continuously high SHALL produce back-to-back frames separated per REQ-026.
REQ-029 Changes to rw/address/wr_data after accept SHALL NOT affect the frame in flight.
REQ-030 spi_clk, cs_n and mosi SHALL be driven directly from flops (glitch-free).
REQ-031 The half-period counter SHALL be 8 bits and count 0..CLK_DIV-1; the bit counter SHALL be 5 bits and count 0..16.

Reset
REQ-032 reset_n=0 SHALL asynchronously force: state=IDLE, cs_n=1, spi_clk=0, mosi=0, busy=0, done=0, rd_data=8'h00, all counters=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse and rd_data cleared.
REQ-034 After reset_n deasserts, SHALL accept start on the first clock edge.

Verification
REQ-035 Write, CLK_DIV=4: address=6'h05, wr_data=8'hA5, rw=0 -> mosi bits 16'h05A5 sampled on rising spi_clk edges; done at cycle 137; rd_data unchanged.
REQ-036 Read: address=6'h10, rw=1, slave model returns 8'h3C in the second byte -> mosi 16'h9000; rd_data=8'h3C at the done pulse.
REQ-037 start pulsed at cycle 20 of an active frame -> ignored, exactly one frame and one done pulse.
REQ-038 reset_n low at cycle 50 of a frame -> cs_n=1 and spi_clk=0 asynchronously; no done pulse; rd_data=8'h00.
REQ-039 start held high, CLK_DIV=2 -> first done at cycle 69; cs_n high ≥3 cycles between frames; second frame correct.
REQ-040 Scenario coverage SHALL count exactly 16 rising and 16 falling spi_clk edges per frame, with spi_clk low whenever cs_n=1.
